tacho: RTL and testbench

- Fan tachometer; downstream companion of the PWM fan driver. Counts fan tach pulses over a programmable gate window.
- Exposes the latched count over the shared 5-bit CSR bus so firmware can close the fan-speed loop by writing new duty cycles to the PWM.
- Runs in the single system clock domain. Slow time bases arrive as clock enables from the shared prescaler.

---
 rtl/tacho_pkg.sv | 41 ++++
 rtl/tacho_input_filter.sv | 50 +++++
 rtl/tacho.sv | 124 ++++++++++++
 tb/tb_tacho.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tacho_pkg.sv
// Shared CSR definitions for the fan tachometer block.
package tacho_pkg;

  // Register offsets relative to the block base address.
  localparam logic [4:0] CTRL_OFS  = 5'd0;
  localparam logic [4:0] CNT_H_OFS = 5'd1;
  localparam logic [4:0] CNT_L_OFS = 5'd2;

  // CTRL register bit positions.
  localparam int CTRL_EN_BIT    = 7;
  localparam int CTRL_VALID_BIT = 6;
  localparam int CTRL_OVF_BIT   = 5;
  localparam int CTRL_SCALE_MSB = 1;
  localparam int CTRL_SCALE_LSB = 0;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_CNT_H = 2'd1,
    REG_CNT_L = 2'd2,
    REG_NONE  = 2'd3
  } reg_sel_e;

  // Map a bus address onto one of the block's registers.
  function automatic reg_sel_e decode_addr(input logic [4:0] addr,
                                           input logic [4:0] base);
    logic [4:0] ofs;
    ofs = addr - base;
    case (ofs)
      CTRL_OFS:  return REG_CTRL;
      CNT_H_OFS: return REG_CNT_H;
      CNT_L_OFS: return REG_CNT_L;
      default:   return REG_NONE;
    endcase
  endfunction

  // Gate window length in gate ticks: 1, 2, 4 or 8.
  function automatic logic [3:0] gate_target(input logic [1:0] scale);
    return 4'd1 << scale;
  endfunction

endpackage

// File: rtl/tacho_input_filter.sv
// Slow board input conditioner: 2-FF synchroniser, agreement filter that
// changes level only after FILTER_LEN identical samples, and rise detector.
module input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_ce,
  input  logic in,
  output logic level,
  output logic rise
);

  logic [1:0]            sync;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] window;
  logic                  level_d;

  // The newest synchronised bit plus the FILTER_LEN-1 previous samples.
  assign window = {hist, sync[1]};

  // Two-stage synchroniser; resets to the idle-high line level.
  // NOTE: clocked blocks use non-blocking assignments so every register
  // sees pre-edge values and the stages do not collapse into one.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], in};
  end

  // Shift history on each sample enable; level follows only unanimous windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= '1;
      level <= 1'b1;
    end else if (sample_ce) begin
      hist <= window[FILTER_LEN-2:0];
      if (&window)       level <= 1'b1;
      else if (~|window) level <= 1'b0;
    end
  end

  // Delayed level for single-cycle rise detection.
  always_ff @(posedge clk) begin
    if (rst) level_d <= 1'b1;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/tacho.sv
// Fan tachometer: counts filtered tach rises over a programmable gate
// window and publishes the latched count on the CSR bus.
module tacho
  import tacho_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR  = 5'h0,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       tach_ce,
  input  logic       gate_ce,
  input  logic       tach_in,
  output logic       tach_en
);

  logic        en;
  logic [1:0]  scale;
  logic        valid;
  logic        ovf;
  logic [15:0] result;
  logic [15:0] acc;
  logic        ovf_acc;
  logic [3:0]  win_cnt;

  logic        rise;
  logic        unused_level;
  logic        unused_di;
  reg_sel_e    reg_sel;
  logic        ctrl_we;
  logic [15:0] acc_next;
  logic        ovf_acc_next;
  logic        win_end;

  input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .sample_ce(tach_ce),
    .in       (tach_in),
    .level    (unused_level),
    .rise     (rise)
  );

  assign reg_sel   = decode_addr(csr_a, BASE_ADDR);
  assign ctrl_we   = csr_we && (reg_sel == REG_CTRL);
  assign tach_en   = en;
  assign unused_di = ^csr_di[CTRL_OVF_BIT:CTRL_SCALE_MSB+1];

  // Saturating accumulate and window-end detection for this cycle.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    acc_next     = acc;
    ovf_acc_next = ovf_acc;
    if (rise) begin
      if (acc == 16'hFFFF) ovf_acc_next = 1'b1;
      else                 acc_next     = acc + 16'd1;
    end
    win_end = en && gate_ce &&
              (({1'b0, win_cnt} + 5'd1) >= {1'b0, gate_target(scale)});
  end

  // CSR read mux; unmapped addresses read zero.
  always_comb begin
    csr_do = 8'h00;
    case (reg_sel)
      REG_CTRL: begin
        csr_do[CTRL_EN_BIT]                   = en;
        csr_do[CTRL_VALID_BIT]                = valid;
        csr_do[CTRL_OVF_BIT]                  = ovf;
        csr_do[CTRL_SCALE_MSB:CTRL_SCALE_LSB] = scale;
      end
      REG_CNT_H: csr_do = result[15:8];
      REG_CNT_L: csr_do = result[7:0];
      default:   csr_do = 8'h00;
    endcase
  end

  // Firmware-writable control fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 1'b0;
      scale <= 2'd0;
    end else if (ctrl_we) begin
      en    <= csr_di[CTRL_EN_BIT];
      scale <= csr_di[CTRL_SCALE_MSB:CTRL_SCALE_LSB];
    end
  end

  // Published result; a window end beats a same-cycle valid clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 16'h0000;
      ovf    <= 1'b0;
      valid  <= 1'b0;
    end else if (win_end) begin
      result <= acc_next;
      ovf    <= ovf_acc_next;
      valid  <= 1'b1;
    end else if (ctrl_we && csr_di[CTRL_VALID_BIT]) begin
      valid  <= 1'b0;
    end
  end

  // Window state: held at zero while disabled, so enabling starts fresh.
  always_ff @(posedge clk) begin
    if (rst || !en || win_end) begin
      acc     <= 16'h0000;
      ovf_acc <= 1'b0;
      win_cnt <= 4'd0;
    end else begin
      acc     <= acc_next;
      ovf_acc <= ovf_acc_next;
      if (gate_ce) win_cnt <= win_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_tacho.sv
// Self-checking bench for tacho: a behavioural model predicts each window
// result into a queue; a monitor compares published windows against it.
module tb_tacho;
  import tacho_pkg::*;

  localparam int FL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       tach_ce;
  logic       gate_ce;
  logic       tach_in;
  logic       tach_en;

  always #5 clk = ~clk;

  tacho #(.BASE_ADDR(5'h0), .FILTER_LEN(FL)) dut (
    .clk    (clk),
    .rst    (rst),
    .csr_a  (csr_a),
    .csr_di (csr_di),
    .csr_we (csr_we),
    .csr_do (csr_do),
    .tach_ce(tach_ce),
    .gate_ce(gate_ce),
    .tach_in(tach_in),
    .tach_en(tach_en)
  );

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [15:0] cnt;
  } win_t;

  win_t exp_q[$];
  win_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (sample-level view of the spec rules).
  bit          m_en, m_valid, m_ovf, m_last, m_level;
  logic [1:0]  m_scale;
  int          m_count, m_win, m_run;
  logic [15:0] m_result;

  function automatic void m_reset();
    m_en = 0; m_valid = 0; m_ovf = 0; m_scale = 2'd0;
    m_count = 0; m_win = 0; m_result = 16'h0000;
    m_last = 1; m_run = FL; m_level = 1;
  endfunction

  function automatic logic [7:0] m_ctrl();
    return {m_en, m_valid, m_ovf, 3'b000, m_scale};
  endfunction

  function automatic void m_sample(input bit v);
    if (v == m_last) m_run++;
    else begin m_last = v; m_run = 1; end
    if (m_run >= FL && m_level != v) begin
      m_level = v;
      if (v && m_en) m_count++;
    end
  endfunction

  function automatic bit m_gate();
    win_t w;
    if (!m_en) return 0;
    m_win++;
    if (m_win < (1 << m_scale)) return 0;
    m_ovf    = (m_count > 65535);
    m_result = m_ovf ? 16'hFFFF : m_count[15:0];
    m_valid  = 1;
    w.ctrl   = {m_en, 1'b1, m_ovf, 3'b000, m_scale};
    w.cnt    = m_result;
    exp_q.push_back(w);
    m_count = 0;
    m_win   = 0;
    return 1;
  endfunction

  function automatic void m_write(input logic [7:0] di, input bit ended);
    if (!di[7]) begin m_count = 0; m_win = 0; end
    m_en    = di[7];
    m_scale = di[1:0];
    if (di[6] && !ended) m_valid = 0;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_rd(input logic [4:0] a, output logic [7:0] d);
    csr_a = a;
    #1;
    d = csr_do;
  endtask

  // CTRL write, optionally with a gate tick in the same cycle.
  task automatic ctrl_wr(input logic [7:0] di, input bit with_gate);
    bit ended;
    @(posedge clk); #1;
    csr_a = CTRL_OFS; csr_di = di; csr_we = 1'b1; gate_ce = with_gate;
    @(posedge clk); #1;
    csr_we = 1'b0; gate_ce = 1'b0;
    ended = with_gate ? m_gate() : 1'b0;
    m_write(di, ended);
  endtask

  // Hold tach_in at v for w filter samples; optionally put a gate tick in
  // the cycle where the resulting rise (if any) is presented.
  task automatic seg(input bit v, input int w, input bit gate_after);
    tach_in = v;
    for (int i = 0; i < w; i++) begin
      repeat (3) @(posedge clk);
      #1 tach_ce = 1'b1;
      @(posedge clk);
      #1 tach_ce = 1'b0;
      m_sample(v);
    end
    if (gate_after) begin
      gate_ce = 1'b1;
      @(posedge clk);
      #1 gate_ce = 1'b0;
      void'(m_gate());
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      seg(1'b0, 3, 1'b0);
      seg(1'b1, 3, 1'b0);
    end
  endtask

  task automatic gate_tick(output bit ended);
    @(posedge clk); #1 gate_ce = 1'b1;
    @(posedge clk); #1 gate_ce = 1'b0;
    ended = m_gate();
  endtask

  task automatic end_window();
    bit e = 0;
    int guard = 0;
    while (!e && guard < 16) begin
      guard++;
      gate_tick(e);
    end
  endtask

  // Wait (bounded) for valid, capture the published window, then W1C it.
  task automatic collect();
    logic [7:0] c, h, l;
    win_t o;
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      csr_rd(CTRL_OFS, c);
      if (c[CTRL_VALID_BIT]) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: got ctrl %h expected valid bit set", c);
    end else begin
      csr_rd(CNT_H_OFS, h);
      csr_rd(CNT_L_OFS, l);
      o.ctrl = c;
      o.cnt  = {h, l};
      obs_q.push_back(o);
    end
    ctrl_wr({m_en, 1'b1, 4'b0000, m_scale}, 1'b0);
    csr_rd(CTRL_OFS, c);
    check("ctrl_after_w1c", {8'h00, c}, {8'h00, m_ctrl()});
  endtask

  // Monitor: compare every published window with the model's prediction.
  initial begin : monitor
    win_t o, e;
    forever begin
      @(negedge clk);
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL window_unexpected: got ctrl=%h cnt=%h expected none",
                   o.ctrl, o.cnt);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_bad++;
            $display("FAIL window: got ctrl=%h cnt=%h expected ctrl=%h cnt=%h",
                     o.ctrl, o.cnt, e.ctrl, e.cnt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] d;
    bit ended;
    int guard;

    rst = 1'b1; csr_a = 5'h0; csr_di = 8'h00; csr_we = 1'b0;
    tach_ce = 1'b0; gate_ce = 1'b0; tach_in = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state and unmapped reads
    csr_rd(CTRL_OFS, d);  check("rst_ctrl", {8'h00, d}, 16'h0000);
    csr_rd(CNT_H_OFS, d); check("rst_cnt_h", {8'h00, d}, 16'h0000);
    csr_rd(CNT_L_OFS, d); check("rst_cnt_l", {8'h00, d}, 16'h0000);
    csr_rd(5'h1F, d);     check("unmapped_1f", {8'h00, d}, 16'h0000);
    csr_rd(5'h03, d);     check("unmapped_03", {8'h00, d}, 16'h0000);
    check("rst_tach_en", {15'h0, tach_en}, 16'h0000);

    // 2: 100 clean pulses in one window
    ctrl_wr(8'h80, 1'b0);
    check("tach_en_on", {15'h0, tach_en}, {15'h0, m_en});
    pulses(100);
    end_window();
    collect();

    // 3: glitch rejection, then one qualifying low pulse
    for (int i = 0; i < 5; i++) begin
      seg(1'b0, 2, 1'b0);
      seg(1'b1, 3, 1'b0);
    end
    end_window();
    collect();
    seg(1'b0, 3, 1'b0);
    seg(1'b1, 3, 1'b0);
    end_window();
    collect();

    // 4: saturation over an 8-tick window, accumulator preloaded near full
    ctrl_wr(8'h00, 1'b0);
    ctrl_wr(8'h83, 1'b0);
    force dut.acc = 16'hFFF0;
    @(posedge clk); #1;
    release dut.acc;
    m_count = 16'hFFF0;
    for (int i = 0; i < 7; i++) begin
      pulses(3);
      gate_tick(ended);
    end
    pulses(3);
    end_window();
    collect();
    pulses(10);
    end_window();
    collect();

    // 5a: rise coincident with the closing gate tick, then an empty window
    ctrl_wr(8'h80, 1'b0);
    pulses(4);
    seg(1'b0, 3, 1'b0);
    seg(1'b1, 3, 1'b1);
    collect();
    end_window();
    collect();

    // 5b: valid W1C in the same cycle as window end
    pulses(2);
    ctrl_wr(8'hC0, 1'b1);
    collect();

    // 6: disable mid-window, result retained, re-enable starts fresh
    pulses(5);
    ctrl_wr(8'h00, 1'b0);
    csr_rd(CNT_L_OFS, d); check("hold_cnt_l", {8'h00, d}, {8'h00, m_result[7:0]});
    csr_rd(CNT_H_OFS, d); check("hold_cnt_h", {8'h00, d}, {8'h00, m_result[15:8]});
    csr_rd(CTRL_OFS, d);  check("hold_ctrl", {8'h00, d}, {8'h00, m_ctrl()});
    check("tach_en_off", {15'h0, tach_en}, {15'h0, m_en});
    pulses(2);
    ctrl_wr(8'h80, 1'b0);
    pulses(3);
    end_window();
    collect();

    // 7: scale reduced below the current tick count ends on next tick
    ctrl_wr(8'h83, 1'b0);
    pulses(1);
    for (int i = 0; i < 3; i++) gate_tick(ended);
    ctrl_wr(8'h81, 1'b0);
    pulses(2);
    end_window();
    collect();

    // 8: reset mid-window publishes nothing
    pulses(4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_reset();
    csr_rd(CTRL_OFS, d);  check("rst2_ctrl", {8'h00, d}, 16'h0000);
    csr_rd(CNT_L_OFS, d); check("rst2_cnt_l", {8'h00, d}, 16'h0000);
    check("rst2_tach_en", {15'h0, tach_en}, 16'h0000);

    // Randomised windows: random segment widths/levels, scales, gate timing
    for (int r = 0; r < 8; r++) begin
      ctrl_wr(8'h00, 1'b0);
      ctrl_wr({1'b1, 5'b00000, 2'($urandom_range(0, 3))}, 1'b0);
      ended = 0;
      guard = 0;
      while (!ended && guard < 60) begin
        guard++;
        seg(1'($urandom_range(0, 1)), $urandom_range(1, 5), 1'b0);
        if ($urandom_range(0, 3) == 0) gate_tick(ended);
      end
      if (!ended) end_window();
      collect();
    end

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL window_missing: got %0d published expected %0d more",
               0, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
